// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one LAT-stage pipelined 64x64 multiplier among NUM_REQ requesters.
// Optional: define MULT_ARB_CHECK_EN to add the sticky proto_err tag/done consistency flag.
module mult_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LAT     = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [64*NUM_REQ-1:0]   req_mcand,
  input  logic [64*NUM_REQ-1:0]   req_mplier,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [64*NUM_REQ-1:0]   resp_product,
  output logic                    mult_start,
  output logic [63:0]             mult_mcand,
  output logic [63:0]             mult_mplier,
  input  logic [63:0]             mult_product,
  input  logic                    mult_done,
  output logic                    busy
`ifdef MULT_ARB_CHECK_EN
  ,
  output logic                    proto_err
`endif
);

  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INFLIGHT = 2'd1,
    ST_HOLD     = 2'd2
  } req_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  req_state_e          state      [NUM_REQ];
  req_state_e          state_next [NUM_REQ];
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     rr_ptr_next;
  logic                busy_next_c;

  logic                grant_any_c;
  logic [ID_W-1:0]     grant_id_c;
  logic [DATA_W-1:0]   grant_mcand_c;
  logic [DATA_W-1:0]   grant_mplier_c;

  logic [ID_W-1:0]     issue_id;
  tag_t                tag_pipe [LAT];
  tag_t                head_c;
  logic                complete_c;

  // Rotating priority search: first idle requester with a valid op at or after rr_ptr.
  always_comb begin : grant_search
    logic [ID_W-1:0] cand;
    cand           = '0;
    grant_any_c    = 1'b0;
    grant_id_c     = '0;
    grant_mcand_c  = '0;
    grant_mplier_c = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!grant_any_c && req_valid[cand] && (state[cand] == ST_IDLE)) begin
        grant_any_c    = 1'b1;
        grant_id_c     = cand;
        grant_mcand_c  = req_mcand[DATA_W*cand +: DATA_W];
        grant_mplier_c = req_mplier[DATA_W*cand +: DATA_W];
      end
    end
  end

  assign req_ready  = grant_any_c ? (NUM_REQ'(1) << grant_id_c) : '0;
  assign head_c     = tag_pipe[LAT-1];
  assign complete_c = head_c.valid & mult_done;

  // Per-requester next state and rr pointer advance.
  always_comb begin
    rr_ptr_next = rr_ptr;
    busy_next_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      state_next[i] = state[i];
      case (state[i])
        ST_IDLE:     if (grant_any_c && (grant_id_c == ID_W'(i))) state_next[i] = ST_INFLIGHT;
        ST_INFLIGHT: if (complete_c && (head_c.id == ID_W'(i)))   state_next[i] = ST_HOLD;
        ST_HOLD:     if (resp_ready[i])                           state_next[i] = ST_IDLE;
        default:                                                  state_next[i] = ST_IDLE;
      endcase
      if (state_next[i] != ST_IDLE) busy_next_c = 1'b1;
    end
    if (grant_any_c) begin
      rr_ptr_next = (grant_id_c == ID_W'(NUM_REQ-1)) ? '0 : grant_id_c + ID_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) state[i] <= ST_IDLE;
      rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) state[i] <= state_next[i];
      rr_ptr <= rr_ptr_next;
    end
  end

  // Issue register: operands are zero whenever no op is launched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mult_start  <= 1'b0;
      mult_mcand  <= '0;
      mult_mplier <= '0;
      issue_id    <= '0;
    end else begin
      mult_start  <= grant_any_c;
      mult_mcand  <= grant_any_c ? grant_mcand_c  : '0;
      mult_mplier <= grant_any_c ? grant_mplier_c : '0;
      issue_id    <= grant_id_c;
    end
  end

  // Owner tags travel alongside the multiplier stages; the head lines up with mult_done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0].valid <= mult_start;
      tag_pipe[0].id    <= issue_id;
      for (int unsigned k = 1; k < LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid   <= '0;
      resp_product <= '0;
      busy         <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        resp_valid[i] <= (state_next[i] == ST_HOLD);
        if (complete_c && (head_c.id == ID_W'(i)) && (state[i] == ST_INFLIGHT)) begin
          resp_product[DATA_W*i +: DATA_W] <= mult_product;
        end
      end
      busy <= busy_next_c;
    end
  end

`ifdef MULT_ARB_CHECK_EN
  // Sticky: a done with no tracked op, or a tracked op whose done never appeared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (mult_done != head_c.valid) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter with a behavioural LAT-stage multiplier and a transaction-level reference model.
module tb_mult_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 8;
  localparam int DW  = 64;

  logic            clock   = 1'b0;
  logic            reset_n = 1'b1;
  logic [NR-1:0]   req_valid  = '0;
  logic [NR-1:0]   resp_ready = '0;
  logic [DW*NR-1:0] req_mcand  = '0;
  logic [DW*NR-1:0] req_mplier = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   resp_valid;
  logic [DW*NR-1:0] resp_product;
  logic            mult_start;
  logic [DW-1:0]   mult_mcand;
  logic [DW-1:0]   mult_mplier;
  logic [DW-1:0]   mult_product;
  logic            mult_done;
  logic            busy;
`ifdef MULT_ARB_CHECK_EN
  logic            proto_err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Multiplier stand-in: fixed latency, never reset.
  logic          mv [LAT] = '{default: 1'b0};
  logic [DW-1:0] mp [LAT] = '{default: '0};
  always @(posedge clock) begin
    mv[0] <= mult_start;
    mp[0] <= mult_mcand * mult_mplier;
    for (int k = 1; k < LAT; k++) begin
      mv[k] <= mv[k-1];
      mp[k] <= mp[k-1];
    end
  end
  assign mult_done    = mv[LAT-1];
  assign mult_product = mp[LAT-1];

  mult_arbiter #(.NUM_REQ(NR), .LAT(LAT)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mcand    (req_mcand),
    .req_mplier   (req_mplier),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .mult_start   (mult_start),
    .mult_mcand   (mult_mcand),
    .mult_mplier  (mult_mplier),
    .mult_product (mult_product),
    .mult_done    (mult_done),
    .busy         (busy)
`ifdef MULT_ARB_CHECK_EN
    ,
    .proto_err    (proto_err)
`endif
  );

  // Transaction-level model: who owns an op, its product, and the cycle its result becomes visible.
  logic [NR-1:0] m_busy = '0;
  logic [DW-1:0] m_prod [NR];
  int            m_due  [NR];
  int            m_ptr = 0;

  function automatic logic [NR-1:0] exp_grant();
    for (int off = 0; off < NR; off++) begin
      int idx;
      idx = (m_ptr + off) % NR;
      if (req_valid[idx] && !m_busy[idx]) return NR'(1) << idx;
    end
    return '0;
  endfunction

  function automatic logic [NR-1:0] exp_rv();
    logic [NR-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i] && (cyc >= m_due[i]);
    return v;
  endfunction

  task automatic model_edge();
    logic [NR-1:0] g;
    logic [NR-1:0] rv;
    g  = exp_grant();
    rv = exp_rv();
    for (int i = 0; i < NR; i++) begin
      if (rv[i] && resp_ready[i]) m_busy[i] = 1'b0;
      if (g[i]) begin
        m_busy[i] = 1'b1;
        m_prod[i] = req_mcand[DW*i +: DW] * req_mplier[DW*i +: DW];
        m_due[i]  = cyc + LAT + 2;
        m_ptr     = (i + 1) % NR;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    req_valid  = '0;
    resp_ready = '1;
    repeat (LAT + 3) step();
    resp_ready = '0;
    reset_n    = 1'b0;
    step();
    reset_n    = 1'b1;
    step();
    m_busy = '0;
    m_ptr  = 0;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    total++; if (resp_valid !== '0 || req_ready !== '0) begin bad++; $display("FAIL rst_valid_ready got=%h/%h want=0/0", resp_valid, req_ready); end
    total++; if (resp_product !== '0) begin bad++; $display("FAIL rst_product got=%h want=0", resp_product); end
    total++; if ({mult_start, mult_mcand, mult_mplier} !== '0) begin bad++; $display("FAIL rst_issue got=%b/%h/%h want=0", mult_start, mult_mcand, mult_mplier); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
`ifdef MULT_ARB_CHECK_EN
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%b want=0", proto_err); end
`endif
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int n;
    req_mcand[63:0]  = 64'd3;
    req_mplier[63:0] = 64'd5;
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", req_ready); end
    step();
    req_valid = '0;
    total++; if ({mult_start, mult_mcand, mult_mplier} !== {1'b1, 64'd3, 64'd5}) begin bad++; $display("FAIL single_issue got=%b/%0d/%0d want=1/3/5", mult_start, mult_mcand, mult_mplier); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    n = 0;
    while (!resp_valid[0] && n < 30) begin step(); n++; end
    total++; if (n != LAT + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d edges", n, LAT + 1); end
    total++; if (resp_product[63:0] !== 64'd15) begin bad++; $display("FAIL single_product got=%0d want=15", resp_product[63:0]); end
    repeat (3) begin
      step();
      total++; if (resp_valid !== 4'b0001 || resp_product[63:0] !== 64'd15) begin bad++; $display("FAIL single_hold got=%b/%0d want=0001/15", resp_valid, resp_product[63:0]); end
    end
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    total++; if (resp_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL single_consume got=%b/%b want=0/0", resp_valid, busy); end
  endtask

  task automatic test_contention();
    logic [DW-1:0] a [NR];
    logic [DW-1:0] b [NR];
    logic [NR-1:0] exp;
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      a[i] = rnd64();
      b[i] = rnd64();
      req_mcand[DW*i +: DW]  = a[i];
      req_mplier[DW*i +: DW] = b[i];
    end
    req_valid  = '1;
    resp_ready = '1;
    for (int k = 0; k < NR; k++) begin
      #1;
      total++; if (req_ready !== (NR'(1) << k)) begin bad++; $display("FAIL cont_grant%0d got=%b want=%b", k, req_ready, NR'(1) << k); end
      step();
      req_valid[k] = 1'b0;
    end
    for (int e = 1; e <= 9; e++) begin
      step();
      exp = (e >= 6) ? (NR'(1) << (e - 6)) : '0;
      total++; if (resp_valid !== exp) begin bad++; $display("FAIL cont_order e=%0d got=%b want=%b", e, resp_valid, exp); end
      if (e >= 6) begin
        total++; if (resp_product[DW*(e-6) +: DW] !== a[e-6] * b[e-6]) begin bad++; $display("FAIL cont_product%0d got=%h want=%h", e - 6, resp_product[DW*(e-6) +: DW], a[e-6] * b[e-6]); end
      end
    end
    req_valid = '1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL cont_rr_wrap got=%b want=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    logic [DW-1:0] a [NR];
    logic [DW-1:0] b [NR];
    int grants [$];
    apply_reset();
    for (int i = 1; i <= 2; i++) begin
      a[i] = rnd64();
      b[i] = rnd64();
      req_mcand[DW*i +: DW]  = a[i];
      req_mplier[DW*i +: DW] = b[i];
    end
    req_valid  = 4'b0110;
    resp_ready = 4'b0110;
    for (int c = 0; c < 80; c++) begin
      #1;
      for (int i = 1; i <= 2; i++) begin
        if (resp_valid[i]) begin
          total++; if (resp_product[DW*i +: DW] !== a[i] * b[i]) begin bad++; $display("FAIL fair_product%0d got=%h want=%h", i, resp_product[DW*i +: DW], a[i] * b[i]); end
        end
        if (req_ready[i]) grants.push_back(i);
      end
      step();
    end
    req_valid = '0;
    total++; if (grants.size() < 8) begin bad++; $display("FAIL fair_count got=%0d want>=8", grants.size()); end
    foreach (grants[j]) begin
      total++; if (grants[j] != ((j % 2 == 0) ? 1 : 2)) begin bad++; $display("FAIL fair_order j=%0d got=%0d want=%0d", j, grants[j], (j % 2 == 0) ? 1 : 2); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int n;
    apply_reset();
    a = rnd64();
    b = rnd64();
    req_mcand[DW*2 +: DW]  = a;
    req_mplier[DW*2 +: DW] = b;
    req_valid  = 4'b0100;
    resp_ready = '0;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant got=%b want=0100", req_ready); end
    step();
    n = 0;
    while (!resp_valid[2] && n < 30) begin
      total++; if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL bp_inflight_ready n=%0d got=%b want=0", n, req_ready[2]); end
      step();
      n++;
    end
    total++; if (resp_valid[2] !== 1'b1 || resp_product[DW*2 +: DW] !== a * b) begin bad++; $display("FAIL bp_result got=%b/%h want=1/%h", resp_valid[2], resp_product[DW*2 +: DW], a * b); end
    repeat (5) begin
      total++; if (req_ready[2] !== 1'b0 || resp_valid[2] !== 1'b1) begin bad++; $display("FAIL bp_hold got=%b/%b want=0/1", req_ready[2], resp_valid[2]); end
      step();
    end
    resp_ready[2] = 1'b1;
    #1;
    total++; if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL bp_ready_indep got=%b want=0", req_ready[2]); end
    step();
    resp_ready[2] = 1'b0;
    total++; if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0) begin bad++; $display("FAIL bp_regrant got=%b/%b want=1/0", req_ready[2], resp_valid[2]); end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    int n;
    apply_reset();
    req_mcand[DW*3 +: DW]  = '1;
    req_mplier[DW*3 +: DW] = 64'd2;
    req_mcand[DW*0 +: DW]  = '1;
    req_mplier[DW*0 +: DW] = '1;
    req_valid  = 4'b1001;
    resp_ready = '0;
    step();
    req_valid[0] = 1'b0;
    step();
    req_valid = '0;
    n = 0;
    while (resp_valid !== 4'b1001 && n < 30) begin step(); n++; end
    total++; if (resp_valid !== 4'b1001) begin bad++; $display("FAIL wrap_valid got=%b want=1001", resp_valid); end
    total++; if (resp_product[DW*3 +: DW] !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL wrap_x2 got=%h want=fffffffffffffffe", resp_product[DW*3 +: DW]); end
    total++; if (resp_product[DW*0 +: DW] !== 64'h1) begin bad++; $display("FAIL wrap_max_sq got=%h want=1", resp_product[DW*0 +: DW]); end
    resp_ready = '1;
    step();
    resp_ready = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] g;
    logic [NR-1:0] rv;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i]  = ($urandom_range(0, 3) != 0);
        resp_ready[i] = ($urandom_range(0, 2) != 0);
        req_mcand[DW*i +: DW]  = ($urandom_range(0, 7) == 0) ? '1 : rnd64();
        req_mplier[DW*i +: DW] = rnd64();
      end
      #1;
      g  = exp_grant();
      rv = exp_rv();
      total++; if (req_ready !== g) begin bad++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, req_ready, g); end
      total++; if (resp_valid !== rv) begin bad++; $display("FAIL rand_resp_valid c=%0d got=%b want=%b", c, resp_valid, rv); end
      total++; if (busy !== (|m_busy)) begin bad++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, busy, |m_busy); end
      for (int i = 0; i < NR; i++) begin
        if (rv[i]) begin
          total++; if (resp_product[DW*i +: DW] !== m_prod[i]) begin bad++; $display("FAIL rand_product%0d c=%0d got=%h want=%h", i, c, resp_product[DW*i +: DW], m_prod[i]); end
        end
      end
      model_edge();
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midop();
    apply_reset();
`ifdef MULT_ARB_CHECK_EN
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL midrst_pre_proto_err got=%b want=0", proto_err); end
`endif
    req_mcand[63:0]  = 64'd7;
    req_mplier[63:0] = 64'd9;
    req_valid  = 4'b0001;
    resp_ready = '0;
    step();
    req_valid = '0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    total++; if (resp_valid !== '0 || busy !== 1'b0 || req_ready !== '0) begin bad++; $display("FAIL midrst_ctrl got=%b/%b/%b want=0/0/0", resp_valid, busy, req_ready); end
    total++; if (resp_product !== '0 || {mult_start, mult_mcand, mult_mplier} !== '0) begin bad++; $display("FAIL midrst_data got=%h/%b want=0/0", resp_product, mult_start); end
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      total++; if (resp_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_after c=%0d got=%b/%b want=0/0", c, resp_valid, busy); end
    end
`ifdef MULT_ARB_CHECK_EN
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL midrst_proto_err got=%b want=1", proto_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
